// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// default operand width and the divide-by-zero quotient pattern.
package div_pkg;

  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  // Quotient reported for a zero divisor: all ones (-1 at any width).
  // Callers truncate to their own width.
  function automatic logic [63:0] dz_quotient();
    return '1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring division step on magnitudes.
// The sign of the incoming partial remainder selects subtract or add of the
// divisor; the new quotient bit is the inverted sign of the result.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   p,
  input  logic [W-1:0] d,
  input  logic         din,
  output logic [W:0]   p_new,
  output logic         q_bit
);

  logic [W:0] p_shift;
  logic [W:0] d_ext;

  // Shift in the next dividend bit, then add or subtract the divisor.
  always_comb begin
    p_shift = {p[W-1:0], din};
    d_ext   = {1'b0, d};
    if (p[W]) begin
      p_new = p_shift + d_ext;
    end else begin
      p_new = p_shift - d_ext;
    end
    q_bit = ~p_new[W];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider, truncating toward zero, one quotient bit per
// clock with a go/over level handshake. Fixed latency of W+2 edges.
// Optional macro DIV_BY_ZERO_FLAG_EN adds the dz output port.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         over
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic         dz
`endif
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [W-1:0] DZ_Q = W'(dz_quotient());

  state_t state, state_n;

  logic [W-1:0] dvd, dvd_n;
  logic [W-1:0] dvs, dvs_n;
  logic [W-1:0] qmag, qmag_n;
  logic [W:0]   p, p_n, p_fix;
  logic [CW-1:0] cnt, cnt_n;
  logic sn, sn_n, sd, sd_n, zd, zd_n;
  logic [W-1:0] quotient_n, remainder_n;
  logic over_n;
  logic [W:0] step_p;
  logic       step_q;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic dz_n;
`endif

  div_step #(.W(W)) u_step (
    .p     (p),
    .d     (dvs),
    .din   (dvd[W-1]),
    .p_new (step_p),
    .q_bit (step_q)
  );

  // Register all state; reset discards any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      qmag      <= '0;
      p         <= '0;
      cnt       <= '0;
      sn        <= 1'b0;
      sd        <= 1'b0;
      zd        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      over      <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
      dz        <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      dvd       <= dvd_n;
      dvs       <= dvs_n;
      qmag      <= qmag_n;
      p         <= p_n;
      cnt       <= cnt_n;
      sn        <= sn_n;
      sd        <= sd_n;
      zd        <= zd_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      over      <= over_n;
`ifdef DIV_BY_ZERO_FLAG_EN
      dz        <= dz_n;
`endif
    end
  end

  // Next-state and datapath update for each FSM state.
  always_comb begin
    state_n     = state;
    dvd_n       = dvd;
    dvs_n       = dvs;
    qmag_n      = qmag;
    p_n         = p;
    cnt_n       = cnt;
    sn_n        = sn;
    sd_n        = sd;
    zd_n        = zd;
    quotient_n  = quotient;
    remainder_n = remainder;
    over_n      = over;
    p_fix       = p[W] ? (p + {1'b0, dvs}) : p;
`ifdef DIV_BY_ZERO_FLAG_EN
    dz_n        = dz;
`endif
    unique case (state)
      IDLE: begin
        if (go) begin
          sn_n    = dividend[W-1];
          sd_n    = divisor[W-1];
          dvd_n   = dividend[W-1] ? -dividend : dividend;
          dvs_n   = divisor[W-1] ? -divisor : divisor;
          zd_n    = (divisor == '0);
          p_n     = '0;
          qmag_n  = '0;
          cnt_n   = CW'(W);
          state_n = ITER;
`ifdef DIV_BY_ZERO_FLAG_EN
          dz_n    = 1'b0;
`endif
        end
      end
      ITER: begin
        // Rotating the dividend feeds its MSB to the step each cycle and
        // leaves the original magnitude in place after W steps, which the
        // divide-by-zero remainder reuses.
        p_n    = step_p;
        qmag_n = {qmag[W-2:0], step_q};
        dvd_n  = {dvd[W-2:0], dvd[W-1]};
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = FIX;
        end
      end
      FIX: begin
        p_n = p_fix;
        if (zd) begin
          quotient_n  = DZ_Q;
          remainder_n = sn ? -dvd : dvd;
        end else begin
          quotient_n  = (sn ^ sd) ? -qmag : qmag;
          remainder_n = sn ? -p_fix[W-1:0] : p_fix[W-1:0];
        end
        over_n  = 1'b1;
        state_n = DONE;
`ifdef DIV_BY_ZERO_FLAG_EN
        dz_n    = zd;
`endif
      end
      DONE: begin
        if (!go) begin
          over_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard testbench for seq_signed_divider (W=8).
module tb_seq_signed_divider;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         over;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic         dz;
`endif

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  seq_signed_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .over      (over)
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    .dz        (dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: C-style truncating division on plain integers.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    e.a = a;
    e.b = b;
    if (ib == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = W'(ia / ib);
      e.r  = W'(ia % ib);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive operands with go and let the sampling edge (edge 1) pass.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(a, b));
    dividend = a;
    divisor  = b;
    go       = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for over, then check latency and results.
  task automatic wait_result(input bit hold);
    int   edges;
    exp_t e;
    edges = 1;
    if (!hold) go = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    while (!over && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency", edges, 10);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check($sformatf("quot %0d/%0d", $signed(e.a), $signed(e.b)), quotient, e.q);
      check($sformatf("rem %0d/%0d", $signed(e.a), $signed(e.b)), remainder, e.r);
`ifdef DIV_BY_ZERO_FLAG_EN
      check("dz", dz, e.dz);
`endif
    end
  endtask

  task automatic back_to_idle();
    logic [W-1:0] q_held;
    logic [W-1:0] r_held;
    q_held = quotient;
    r_held = remainder;
    go = 1'b0;
    @(posedge clk);
    #1;
    check("over_low", over, 0);
    check("quot_hold_idle", quotient, q_held);
    check("rem_hold_idle", remainder, r_held);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b);
    wait_result(1'b0);
    back_to_idle();
  endtask

  initial begin
    logic [W-1:0] q_held;
    rst      = 1'b1;
    go       = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_over", over, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("rst_dz", dz, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(8'd120, 8'd3);
    run(8'(-7), 8'd2);
    run(8'd7, 8'(-2));
    run(8'h80, 8'(-1));
    run(8'h80, 8'd1);
    run(8'd25, 8'd0);
    run(8'(-25), 8'd0);
    run(8'd127, 8'h80);
    run(8'h80, 8'h80);
    run(8'd0, 8'd5);
    for (int i = 0; i < 16; i++) begin
      run(W'($urandom), W'($urandom));
    end

    // Asynchronous reset in the middle of an iteration.
    start_op(8'd50, 8'd3);
    go = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_over", over, 0);
    check("midrst_quot", quotient, 0);
    check("midrst_rem", remainder, 0);
    #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    run(8'd100, 8'd7);

    // go held through DONE must not restart the operation.
    start_op(8'(-100), 8'd9);
    wait_result(1'b1);
    q_held = quotient;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_over", over, 1);
      check("hold_quot", quotient, q_held);
    end
    back_to_idle();
    run(8'd9, 8'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
